// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped I/O block beside the core's data/instruction memories.
// Claims every access with addr[31]=1 and decodes addr[7:0]. It provides a UART
// status/data window, free-running cycle and retired-instruction counters, and a
// read-data register with the same one-cycle latency as the block RAMs.
module mmio_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wea,
  input  logic        re,
  input  logic        instr_valid,
  output logic [31:0] rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam logic [7:0] OFF_UART_CTRL = 8'h00;
  localparam logic [7:0] OFF_UART_RX   = 8'h04;
  localparam logic [7:0] OFF_UART_TX   = 8'h08;
  localparam logic [7:0] OFF_CYCLE     = 8'h10;
  localparam logic [7:0] OFF_INSTR     = 8'h14;
  localparam logic [7:0] OFF_CNT_CLR   = 8'h18;

  logic        hit;
  logic [7:0]  off;
  logic        tx_wr;
  logic        tx_handshake;
  logic        cnt_clr;
  logic [31:0] rd_val;

  logic        tx_full_q,  tx_full_d;
  logic [7:0]  tx_byte_q,  tx_byte_d;
  logic [31:0] cycle_q,    cycle_d;
  logic [31:0] instr_q,    instr_d;
  logic [31:0] rdata_q,    rdata_d;

  // Upper address bits and upper store lanes are intentionally unused.
  logic unused_bits;
  assign unused_bits = ^{addr[30:8], wdata[31:8]};

  assign hit          = addr[31];
  assign off          = addr[7:0];
  assign tx_handshake = tx_full_q & uart_tx_ready;
  assign tx_wr        = hit & (off == OFF_UART_TX) & wea[0];
  assign cnt_clr      = hit & (off == OFF_CNT_CLR) & (wea != 4'b0000);

  // Pop strobe to the receiver: combinational, one pulse per read of a full rx.
  assign uart_rx_ready = re & hit & (off == OFF_UART_RX) & uart_rx_valid;

  assign uart_tx_valid = tx_full_q;
  assign uart_tx_data  = tx_byte_q;
  assign rdata         = rdata_q;

  // Read mux over pre-edge state, so a same-cycle write never affects the read.
  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    rd_val = 32'h0;
    case (off)
      OFF_UART_CTRL: rd_val = {30'h0, uart_rx_valid, ~tx_full_q};
      OFF_UART_RX:   rd_val = uart_rx_valid ? {24'h0, uart_rx_data} : 32'h0;
      OFF_CYCLE:     rd_val = cycle_q;
      OFF_INSTR:     rd_val = instr_q;
      default:       rd_val = 32'h0;
    endcase
  end

  // Next-state for the TX holding register, the counters and read data.
  always_comb begin
    tx_full_d = tx_full_q;
    tx_byte_d = tx_byte_q;
    // A write is accepted when the holder is empty or drains this same cycle;
    // otherwise it is dropped and software must poll the control bit.
    if (tx_wr && (!tx_full_q || tx_handshake)) begin
      tx_full_d = 1'b1;
      tx_byte_d = wdata[7:0];
    end else if (tx_handshake) begin
      tx_full_d = 1'b0;
    end

    // Clear beats a coincident increment; both counters wrap silently.
    cycle_d = cnt_clr ? 32'h0 : cycle_q + 32'h1;
    instr_d = cnt_clr ? 32'h0 : instr_q + {31'h0, instr_valid};

    rdata_d = (re && hit) ? rd_val : rdata_q;
  end

  // State registers; reset drops any pending TX byte immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_full_q <= 1'b0;
      tx_byte_q <= 8'h0;
      cycle_q   <= 32'h0;
      instr_q   <= 32'h0;
      rdata_q   <= 32'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      tx_full_q <= tx_full_d;
      tx_byte_q <= tx_byte_d;
      cycle_q   <= cycle_d;
      instr_q   <= instr_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Testbench for mmio_ctrl. Expected read data is pushed to a queue when the load
// is issued and popped when rdata appears one cycle later. Counter expectations
// come from a bench-side reference count advanced on every clock edge.
module tb_mmio_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wea;
  logic        re;
  logic        instr_valid;
  logic [31:0] rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;

  mmio_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .addr          (addr),
    .wdata         (wdata),
    .wea           (wea),
    .re            (re),
    .instr_valid   (instr_valid),
    .rdata         (rdata),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] cyc_ref;
  logic [31:0] ins_ref;
  logic [31:0] rdata_ref;

  // One clock: advance the reference counters from the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (addr[31] && addr[7:0] == 8'h18 && wea != 4'h0) begin
        cyc_ref = 32'h0;
        ins_ref = 32'h0;
      end else begin
        cyc_ref = cyc_ref + 32'h1;
        ins_ref = ins_ref + {31'h0, instr_valid};
      end
    end
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] we, input logic r);
    addr  = a;
    wdata = wd;
    wea   = we;
    re    = r;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  // Issue a load for one cycle and queue the value it must return.
  task automatic issue_read(input logic [31:0] a, input logic [31:0] exp);
    drive(a, 32'h0, 4'h0, 1'b1);
    exp_q.push_back(exp);
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0; uart_tx_ready = 1'b0;
    uart_rx_data = 8'h0; uart_rx_valid = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_vec++; if (uart_tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b want 0", uart_tx_valid); end
    n_vec++; if (uart_tx_data !== 8'h0) begin n_err++; $display("FAIL reset_tx_data: got %h want 0", uart_tx_data); end
    n_vec++; if (uart_rx_ready !== 1'b0) begin n_err++; $display("FAIL reset_rx_ready: got %b want 0", uart_rx_ready); end
    cyc_ref = 32'h0; ins_ref = 32'h0; rdata_ref = 32'h0;
    rst_n = 1'b1;
    repeat (10) tick();
    issue_read(32'h8000_0010, cyc_ref);
    exp_v = exp_q.pop_front(); rdata_ref = exp_v;
    n_vec++; if (rdata !== exp_v || exp_v !== 32'd10) begin n_err++; $display("FAIL reset_cycle_read: got %h want %h", rdata, exp_v); end
  endtask

  task automatic test_tx_write();
    uart_tx_ready = 1'b0;
    // wea[0]=0 on the tx data register is ignored
    drive(32'h8000_0008, 32'h0000_0077, 4'b0010, 1'b0); tick(); idle();
    n_vec++; if (uart_tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_lane_ignored: valid %b want 0", uart_tx_valid); end
    // Same-cycle read of control sees the pre-write state (empty -> bit0=1)
    drive(32'h8000_0000, 32'h0, 4'h0, 1'b1); exp_q.push_back(32'h1); tick(); idle();
    exp_v = exp_q.pop_front(); rdata_ref = exp_v;
    n_vec++; if (rdata !== exp_v) begin n_err++; $display("FAIL ctrl_empty: got %h want %h", rdata, exp_v); end
    drive(32'h8000_0008, 32'h0000_0041, 4'b0001, 1'b0); tick(); idle();
    n_vec++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin n_err++; $display("FAIL tx_load: valid %b data %h want 1/41", uart_tx_valid, uart_tx_data); end
    issue_read(32'h8000_0000, 32'h0);
    exp_v = exp_q.pop_front(); rdata_ref = exp_v;
    n_vec++; if (rdata !== exp_v) begin n_err++; $display("FAIL ctrl_full: got %h want %h", rdata, exp_v); end
    uart_tx_ready = 1'b1; tick();
    n_vec++; if (uart_tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_drain: valid %b want 0", uart_tx_valid); end
    issue_read(32'h8000_0000, 32'h1);
    uart_tx_ready = 1'b0;
    exp_v = exp_q.pop_front(); rdata_ref = exp_v;
    n_vec++; if (rdata !== exp_v) begin n_err++; $display("FAIL ctrl_drained: got %h want %h", rdata, exp_v); end
  endtask

  task automatic test_back_to_back();
    uart_tx_ready = 1'b0;
    drive(32'h8000_0008, 32'h0000_0041, 4'b0001, 1'b0); tick();
    uart_tx_ready = 1'b1;
    drive(32'h8000_0008, 32'h0000_0042, 4'b0001, 1'b0); tick();
    uart_tx_ready = 1'b0;
    n_vec++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h42) begin n_err++; $display("FAIL b2b_accept: valid %b data %h want 1/42", uart_tx_valid, uart_tx_data); end
    drive(32'h8000_0008, 32'h0000_0043, 4'b1111, 1'b0); tick(); idle();
    n_vec++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h42) begin n_err++; $display("FAIL b2b_drop: valid %b data %h want 1/42", uart_tx_valid, uart_tx_data); end
    tick();
    n_vec++; if (uart_tx_data !== 8'h42) begin n_err++; $display("FAIL b2b_stable: data %h want 42", uart_tx_data); end
    uart_tx_ready = 1'b1; tick(); uart_tx_ready = 1'b0;
    n_vec++; if (uart_tx_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: valid %b want 0", uart_tx_valid); end
  endtask

  task automatic test_rx();
    uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
    drive(32'h8000_0004, 32'h0, 4'h0, 1'b1); exp_q.push_back(32'h0000_005A);
    #1;
    n_vec++; if (uart_rx_ready !== 1'b1) begin n_err++; $display("FAIL rx_pop: ready %b want 1", uart_rx_ready); end
    tick(); idle(); #1;
    n_vec++; if (uart_rx_ready !== 1'b0) begin n_err++; $display("FAIL rx_pop_len: ready %b want 0", uart_rx_ready); end
    exp_v = exp_q.pop_front(); rdata_ref = exp_v;
    n_vec++; if (rdata !== exp_v) begin n_err++; $display("FAIL rx_data: got %h want %h", rdata, exp_v); end
    // Control read with rx full: no pop strobe, bit1 set
    drive(32'h8000_0000, 32'h0, 4'h0, 1'b1); exp_q.push_back(32'h3); #1;
    n_vec++; if (uart_rx_ready !== 1'b0) begin n_err++; $display("FAIL rx_ctrl_nopop: ready %b want 0", uart_rx_ready); end
    tick(); idle();
    exp_v = exp_q.pop_front(); rdata_ref = exp_v;
    n_vec++; if (rdata !== exp_v) begin n_err++; $display("FAIL rx_ctrl: got %h want %h", rdata, exp_v); end
    uart_rx_valid = 1'b0;
    drive(32'h8000_0004, 32'h0, 4'h0, 1'b1); exp_q.push_back(32'h0); #1;
    n_vec++; if (uart_rx_ready !== 1'b0) begin n_err++; $display("FAIL rx_empty_pop: ready %b want 0", uart_rx_ready); end
    tick(); idle();
    exp_v = exp_q.pop_front(); rdata_ref = exp_v;
    n_vec++; if (rdata !== exp_v) begin n_err++; $display("FAIL rx_empty: got %h want %h", rdata, exp_v); end
  endtask

  task automatic test_counters();
    // Write to a read-only counter with a same-cycle read: no effect, pre-edge value
    drive(32'h8000_0010, 32'hFFFF_FFFF, 4'b1111, 1'b1); exp_q.push_back(cyc_ref); tick(); idle();
    exp_v = exp_q.pop_front(); rdata_ref = exp_v;
    n_vec++; if (rdata !== exp_v) begin n_err++; $display("FAIL cnt_ro_write: got %h want %h", rdata, exp_v); end
    // Counter wrap from a forced preload
    force dut.cycle_q = 32'hFFFF_FFFE;
    cyc_ref = 32'hFFFF_FFFE;
    #1 release dut.cycle_q;
    tick();
    issue_read(32'h8000_0010, cyc_ref);
    exp_v = exp_q.pop_front(); rdata_ref = exp_v;
    n_vec++; if (rdata !== exp_v || exp_v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL cnt_max: got %h want %h", rdata, exp_v); end
    issue_read(32'h8000_0010, cyc_ref);
    exp_v = exp_q.pop_front(); rdata_ref = exp_v;
    n_vec++; if (rdata !== exp_v) begin n_err++; $display("FAIL cnt_wrap: got %h want %h", rdata, exp_v); end
    // Retired-instruction count, with addr[30:8] ignored on the read
    instr_valid = 1'b1;
    repeat (5) tick();
    instr_valid = 1'b0;
    issue_read(32'hFFFF_FF14, ins_ref);
    exp_v = exp_q.pop_front(); rdata_ref = exp_v;
    n_vec++; if (rdata !== exp_v) begin n_err++; $display("FAIL instr_cnt: got %h want %h", rdata, exp_v); end
    // Clear coinciding with an increment: clear wins
    instr_valid = 1'b1;
    drive(32'h8000_0018, 32'h0, 4'b0001, 1'b0); tick(); idle();
    instr_valid = 1'b0;
    issue_read(32'h8000_0010, cyc_ref);
    exp_v = exp_q.pop_front(); rdata_ref = exp_v;
    n_vec++; if (rdata !== 32'h0 || exp_v !== 32'h0) begin n_err++; $display("FAIL clr_cycle: got %h want 0", rdata); end
    issue_read(32'h8000_0014, ins_ref);
    exp_v = exp_q.pop_front(); rdata_ref = exp_v;
    n_vec++; if (rdata !== 32'h0 || exp_v !== 32'h0) begin n_err++; $display("FAIL clr_instr: got %h want 0", rdata); end
    // Unmapped and write-only offsets read as zero
    issue_read(32'h8000_000C, 32'h0);
    exp_v = exp_q.pop_front(); rdata_ref = exp_v;
    n_vec++; if (rdata !== exp_v) begin n_err++; $display("FAIL unmapped_rd: got %h want %h", rdata, exp_v); end
  endtask

  task automatic test_miss();
    // Leave a nonzero value on rdata so a spurious update is visible
    issue_read(32'h8000_0010, cyc_ref);
    exp_v = exp_q.pop_front(); rdata_ref = exp_v;
    n_vec++; if (rdata !== exp_v) begin n_err++; $display("FAIL miss_pre: got %h want %h", rdata, exp_v); end
    uart_rx_valid = 1'b1; uart_rx_data = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(32'h1000_0000, 32'h0000_0055, 4'b1111, 1'b1);
        1: drive(32'h1000_0008, 32'h0000_0055, 4'b1111, 1'b1);
        default: drive(32'h1000_0018, 32'h0000_0055, 4'b1111, 1'b1);
      endcase
      #1;
      n_vec++; if (uart_rx_ready !== 1'b0) begin n_err++; $display("FAIL miss_rx_ready%0d: got %b want 0", i, uart_rx_ready); end
      tick();
      n_vec++; if (rdata !== rdata_ref || uart_tx_valid !== 1'b0) begin n_err++; $display("FAIL miss_state%0d: rdata %h valid %b want %h/0", i, rdata, uart_tx_valid, rdata_ref); end
    end
    drive(32'h1000_0004, 32'h0, 4'h0, 1'b1); #1;
    n_vec++; if (uart_rx_ready !== 1'b0) begin n_err++; $display("FAIL miss_rx_pop: got %b want 0", uart_rx_ready); end
    tick(); idle();
    uart_rx_valid = 1'b0;
    // The miss on 0x18 must not have cleared the counter
    issue_read(32'h8000_0010, cyc_ref);
    exp_v = exp_q.pop_front(); rdata_ref = exp_v;
    n_vec++; if (rdata !== exp_v) begin n_err++; $display("FAIL miss_cnt: got %h want %h", rdata, exp_v); end
  endtask

  task automatic test_async_reset();
    uart_tx_ready = 1'b0;
    drive(32'h8000_0008, 32'h0000_00AB, 4'b0001, 1'b0); tick(); idle();
    n_vec++; if (uart_tx_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre: valid %b want 1", uart_tx_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (uart_tx_valid !== 1'b0 || rdata !== 32'h0) begin n_err++; $display("FAIL arst_now: valid %b rdata %h want 0/0", uart_tx_valid, rdata); end
    tick();
    rst_n = 1'b1;
    cyc_ref = 32'h0; ins_ref = 32'h0;
    tick();
    n_vec++; if (uart_tx_valid !== 1'b0 || uart_tx_data !== 8'h0) begin n_err++; $display("FAIL arst_lost: valid %b data %h want 0/0", uart_tx_valid, uart_tx_data); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_tx_write();
    test_back_to_back();
    test_rx();
    test_counters();
    test_miss();
    test_async_reset();
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
